// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package fetch_pkg;

   localparam int DEFAULT_DATA_WIDTH    = 20;
   localparam int DEFAULT_ADDRESS_WIDTH = 8;

   // The opcode occupies the top OPCODE_WIDTH bits of every instruction word.
   localparam int          OPCODE_WIDTH = 4;
   localparam logic [3:0]  HALT_OPCODE  = 4'hF;

   typedef enum logic [1:0] {
      ST_START  = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// Program-counter control channel between the fetch controller and pc_reg.
// Handshake: no valid/ready; load and inc are single-cycle strobes, load wins over inc,
// pc is the registered PC and always reflects the current fetch address.
interface fetch_if #(
   parameter int AW = 8
) ();
   logic          inc;
   logic          load;
   logic [AW-1:0] target;
   logic [AW-1:0] pc;

   modport master (output inc, output load, output target, input pc);
   modport slave  (input inc, input load, input target, output pc);
endinterface

// File: rtl/pc_reg.sv
// Program counter with redirect / increment / hold selection.
module pc_reg #(
   parameter int AW = 8
) (
   input  logic    clk,
   input  logic    rst,
   fetch_if.slave  bus
);

   logic [AW-1:0] pc_d;
   logic [AW-1:0] pc_q;

   // Increment wraps naturally modulo 2^AW.
   always_comb begin
      pc_d = pc_q;
      if (bus.load) begin
         pc_d = bus.target;
      end else if (bus.inc) begin
         pc_d = pc_q + AW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign bus.pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Single-issue instruction fetch stage with IF/ID register and saturating issue counter.
// Optional halt detection is enabled by defining FETCH_HALT_EN.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
   parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic [ADDRESS_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0]    imem_instr,
   input  logic                     stall,
   input  logic                     branch_taken,
   input  logic [ADDRESS_WIDTH-1:0] branch_target,
   output logic [DATA_WIDTH-1:0]    if_instr,
   output logic [ADDRESS_WIDTH-1:0] if_pc,
   output logic                     if_valid,
   output logic [15:0]              fetch_count,
   output logic [1:0]               dbg_state
);

   localparam logic [1:0] START  = ST_START;
   localparam logic [1:0] RUN    = ST_RUN;
   localparam logic [1:0] HALTED = ST_HALTED;

   logic [1:0]               state_d,  state_q;
   logic [DATA_WIDTH-1:0]    instr_d,  instr_q;
   logic [ADDRESS_WIDTH-1:0] ipc_d,    ipc_q;
   logic                     valid_d,  valid_q;
   logic [15:0]              count_d,  count_q;
   logic                     pc_inc;
   logic                     pc_load;
   logic                     halt_pending;

   fetch_if #(.AW(ADDRESS_WIDTH)) pc_bus ();

   pc_reg #(.AW(ADDRESS_WIDTH)) u_pc_reg (
      .clk (clk),
      .rst (rst),
      .bus (pc_bus)
   );

   assign pc_bus.inc    = pc_inc;
   assign pc_bus.load   = pc_load;
   assign pc_bus.target = branch_target;
   assign imem_addr     = pc_bus.pc;

   // A halt instruction is acted on once it has been presented downstream.
`ifdef FETCH_HALT_EN
   assign halt_pending = valid_q &&
                         (instr_q[DATA_WIDTH-1 -: OPCODE_WIDTH] == HALT_OPCODE);
`else
   assign halt_pending = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      valid_d = valid_q;
      count_d = count_q;
      pc_inc  = 1'b0;
      pc_load = 1'b0;
      case (state_q)
         START: begin
            valid_d = 1'b0;
            state_d = RUN;
         end
         RUN: begin
            if (branch_taken) begin
               pc_load = 1'b1;
               valid_d = 1'b0;
            end else if (stall) begin
               valid_d = valid_q;
            end else if (halt_pending) begin
               valid_d = 1'b0;
               state_d = HALTED;
            end else begin
               instr_d = imem_instr;
               ipc_d   = pc_bus.pc;
               valid_d = 1'b1;
               pc_inc  = 1'b1;
               if (count_q != 16'hFFFF) begin
                  count_d = count_q + 16'd1;
               end
            end
         end
         HALTED: begin
            valid_d = 1'b0;
            if (branch_taken) begin
               pc_load = 1'b1;
               state_d = RUN;
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = START;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= START;
         instr_q <= '0;
         ipc_q   <= '0;
         valid_q <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
         valid_q <= valid_d;
         count_q <= count_d;
      end
   end

   assign if_instr    = instr_q;
   assign if_pc       = ipc_q;
   assign if_valid    = valid_q;
   assign fetch_count = count_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed table, halt/reset sequences and a randomized run against a model.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  imem_addr;
   logic [19:0] imem_instr;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [7:0]  branch_target = 8'h00;
   logic [19:0] if_instr;
   logic [7:0]  if_pc;
   logic        if_valid;
   logic [15:0] fetch_count;
   logic [1:0]  dbg_state;

   logic [19:0] mem [256];
   int          n_vec = 0;
   int          n_bad = 0;

   // reference model state
   bit          m_started;
   bit          m_halted;
   int          m_pc;
   logic [19:0] m_instr;
   int          m_ipc;
   bit          m_valid;
   int          m_count;

   typedef struct {
      bit          stall;
      bit          br;
      logic [7:0]  tgt;
      logic [7:0]  exp_pc;
      logic [7:0]  exp_addr;
      bit          exp_valid;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t vec [17];

   always #5 clk = ~clk;

   assign imem_instr = mem[imem_addr];

   fetch_unit dut (
      .clk           (clk),
      .rst           (rst),
      .imem_addr     (imem_addr),
      .imem_instr    (imem_instr),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .if_instr      (if_instr),
      .if_pc         (if_pc),
      .if_valid      (if_valid),
      .fetch_count   (fetch_count),
      .dbg_state     (dbg_state)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_default();
      for (int a = 0; a < 256; a++) mem[a] = 20'h00100 + 20'(a);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      stall = 1'b0;
      branch_taken = 1'b0;
      branch_target = 8'h00;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_started = 0; m_halted = 0; m_pc = 0; m_instr = '0;
      m_ipc = 0; m_valid = 0; m_count = 0;
   endtask

   // Behavioural step for one clock edge, using the inputs present before the edge.
   task automatic model_step();
      bit halt_en;
`ifdef FETCH_HALT_EN
      halt_en = 1;
`else
      halt_en = 0;
`endif
      if (!m_started) begin
         m_started = 1;
      end else if (m_halted) begin
         if (branch_taken) begin
            m_pc = int'(branch_target);
            m_halted = 0;
         end
      end else if (branch_taken) begin
         m_pc = int'(branch_target);
         m_valid = 0;
      end else if (!stall) begin
         if (halt_en && m_valid && (m_instr[19:16] == 4'hF)) begin
            m_valid = 0;
            m_halted = 1;
         end else begin
            m_instr = mem[m_pc];
            m_ipc = m_pc;
            m_valid = 1;
            m_pc = (m_pc + 1) % 256;
            if (m_count < 65535) m_count++;
         end
      end
   endtask

   task automatic check_model(input int cyc);
      chk($sformatf("rnd%0d_addr", cyc),  32'(imem_addr),   32'(m_pc));
      chk($sformatf("rnd%0d_valid", cyc), 32'(if_valid),    32'(m_valid));
      chk($sformatf("rnd%0d_pc", cyc),    32'(if_pc),       32'(m_ipc));
      chk($sformatf("rnd%0d_instr", cyc), 32'(if_instr),    32'(m_instr));
      chk($sformatf("rnd%0d_cnt", cyc),   32'(fetch_count), 32'(m_count));
   endtask

   initial begin
      vec[0]  = '{0, 0, 8'h00, 8'h00, 8'h00, 0, 16'd0};
      vec[1]  = '{0, 0, 8'h00, 8'h00, 8'h01, 1, 16'd1};
      vec[2]  = '{0, 0, 8'h00, 8'h01, 8'h02, 1, 16'd2};
      vec[3]  = '{0, 0, 8'h00, 8'h02, 8'h03, 1, 16'd3};
      vec[4]  = '{0, 0, 8'h00, 8'h03, 8'h04, 1, 16'd4};
      vec[5]  = '{0, 0, 8'h00, 8'h04, 8'h05, 1, 16'd5};
      vec[6]  = '{0, 0, 8'h00, 8'h05, 8'h06, 1, 16'd6};
      vec[7]  = '{1, 0, 8'h00, 8'h05, 8'h06, 1, 16'd6};
      vec[8]  = '{1, 0, 8'h00, 8'h05, 8'h06, 1, 16'd6};
      vec[9]  = '{1, 0, 8'h00, 8'h05, 8'h06, 1, 16'd6};
      vec[10] = '{0, 0, 8'h00, 8'h06, 8'h07, 1, 16'd7};
      vec[11] = '{1, 1, 8'h40, 8'h06, 8'h40, 0, 16'd7};
      vec[12] = '{0, 0, 8'h00, 8'h40, 8'h41, 1, 16'd8};
      vec[13] = '{0, 1, 8'hFE, 8'h40, 8'hFE, 0, 16'd8};
      vec[14] = '{0, 0, 8'h00, 8'hFE, 8'hFF, 1, 16'd9};
      vec[15] = '{0, 0, 8'h00, 8'hFF, 8'h00, 1, 16'd10};
      vec[16] = '{0, 0, 8'h00, 8'h00, 8'h01, 1, 16'd11};

      fill_default();
      do_reset();

      chk("rst_valid", 32'(if_valid),    32'd0);
      chk("rst_pc",    32'(if_pc),       32'd0);
      chk("rst_instr", 32'(if_instr),    32'd0);
      chk("rst_cnt",   32'(fetch_count), 32'd0);
      chk("rst_addr",  32'(imem_addr),   32'd0);
      chk("rst_state", 32'(dbg_state),   32'(fetch_pkg::ST_START));

      for (int i = 0; i < 17; i++) begin
         stall = vec[i].stall;
         branch_taken = vec[i].br;
         branch_target = vec[i].tgt;
         tick();
         chk($sformatf("tbl%0d_addr", i),  32'(imem_addr),   32'(vec[i].exp_addr));
         chk($sformatf("tbl%0d_pc", i),    32'(if_pc),       32'(vec[i].exp_pc));
         chk($sformatf("tbl%0d_valid", i), 32'(if_valid),    32'(vec[i].exp_valid));
         chk($sformatf("tbl%0d_cnt", i),   32'(fetch_count), 32'(vec[i].exp_cnt));
         if (vec[i].exp_valid)
            chk($sformatf("tbl%0d_instr", i), 32'(if_instr), 32'h100 + 32'(vec[i].exp_pc));
      end

      // halt instruction at address 3
      mem[3] = 20'hF0000;
      do_reset();
      for (int i = 0; i < 5; i++) tick();
      chk("halt_pc",    32'(if_pc),    32'd3);
      chk("halt_valid", 32'(if_valid), 32'd1);
      chk("halt_instr", 32'(if_instr), 32'hF0000);
      tick();
`ifdef FETCH_HALT_EN
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("halted%0d_valid", i), 32'(if_valid),    32'd0);
         chk($sformatf("halted%0d_addr", i),  32'(imem_addr),   32'd4);
         chk($sformatf("halted%0d_cnt", i),   32'(fetch_count), 32'd4);
         stall = (i % 2 == 0);
         tick();
      end
      stall = 1'b0;
      branch_taken = 1'b1;
      branch_target = 8'h00;
      tick();
      branch_taken = 1'b0;
      chk("resume_valid0", 32'(if_valid),  32'd0);
      chk("resume_addr",   32'(imem_addr), 32'd0);
      tick();
      chk("resume_pc",     32'(if_pc),     32'd0);
      chk("resume_valid",  32'(if_valid),  32'd1);
`else
      chk("nohalt_pc",    32'(if_pc),    32'd4);
      chk("nohalt_valid", 32'(if_valid), 32'd1);
      chk("nohalt_instr", 32'(if_instr), 32'h00104);
`endif
      mem[3] = 20'h00103;

      // asynchronous reset in the middle of a stall
      do_reset();
      for (int i = 0; i < 4; i++) tick();
      stall = 1'b1;
      tick();
      tick();
      chk("pre_arst_pc", 32'(if_pc), 32'd2);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_valid", 32'(if_valid),    32'd0);
      chk("arst_pc",    32'(if_pc),       32'd0);
      chk("arst_instr", 32'(if_instr),    32'd0);
      chk("arst_cnt",   32'(fetch_count), 32'd0);
      chk("arst_addr",  32'(imem_addr),   32'd0);
      @(negedge clk);
      stall = 1'b0;
      rst = 1'b0;
      tick();
      chk("arst_start_valid", 32'(if_valid), 32'd0);
      tick();
      chk("arst_restart_pc",    32'(if_pc),    32'd0);
      chk("arst_restart_valid", 32'(if_valid), 32'd1);
      chk("arst_restart_cnt",   32'(fetch_count), 32'd1);

      // randomized run against the reference model
      for (int a = 0; a < 256; a++) mem[a] = 20'($urandom);
      do_reset();
      for (int c = 0; c < 600; c++) begin
         stall = ($urandom_range(0, 9) < 3);
         branch_taken = ($urandom_range(0, 9) == 0);
         branch_target = 8'($urandom_range(0, 255));
         model_step();
         tick();
         check_model(c);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
